fifo_read_streamer: RTL and testbench

//  Read-side drain engine for asynFIFO, clocked in the read domain.

---
 rtl/fifo_read_streamer.sv | 59 +++++
 tb/tb_fifo_read_streamer.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/fifo_read_streamer.sv
// fifo_read_streamer: drains asynFIFO's read port into a 2-entry valid/ready output buffer,
// absorbing the FIFO's one-cycle registered read latency.
module fifo_read_streamer #(
    parameter int data_size = 8,
    parameter int cnt_size  = 16
) (
    input  logic                 read_clk,
    input  logic                 read_rst_n,
    input  logic                 fifo_empty,
    input  logic [data_size-1:0] read_data,
    output logic                 read_en,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [data_size-1:0] out_data,
    output logic [1:0]           out_level,
    output logic [cnt_size-1:0]  out_count
);
    logic [data_size-1:0] slot0_q, slot0_d, slot1_q, slot1_d;
    logic [1:0]           level_q, level_d, after_pop;
    logic                 inflight_q, inflight_d, pop;
    logic [cnt_size-1:0]  count_q, count_d;

    always_comb begin
        pop        = (level_q != 2'd0) && out_ready;
        after_pop  = level_q - {1'b0, pop};
        // Reserve room for the word already in flight before issuing another pop.
        read_en    = read_rst_n && !fifo_empty && (({1'b0, after_pop} + {2'b0, inflight_q}) < 3'd2);
        inflight_d = read_en;
        slot0_d    = (inflight_q && after_pop == 2'd0) ? read_data : pop ? slot1_q : slot0_q;
        slot1_d    = (inflight_q && after_pop != 2'd0) ? read_data : slot1_q;
        level_d    = after_pop + {1'b0, inflight_q};
        count_d    = count_q + cnt_size'(pop);
    end

    always_ff @(posedge read_clk) begin
        if (!read_rst_n) begin
            slot0_q    <= '0;
            slot1_q    <= '0;
            level_q    <= '0;
            inflight_q <= 1'b0;
            count_q    <= '0;
        end else begin
            slot0_q    <= slot0_d;
            slot1_q    <= slot1_d;
            level_q    <= level_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge read_clk) begin
        if (read_rst_n) assert (!(inflight_q && after_pop == 2'd2));
    end

    assign out_valid = (level_q != 2'd0);
    assign out_data  = read_rst_n ? slot0_q : '0;
    assign out_level = level_q;
    assign out_count = count_q;
endmodule

// File: tb/tb_fifo_read_streamer.sv
// tb_fifo_read_streamer: queue-based FIFO and scoreboard model driving fifo_read_streamer
// with directed and random stimulus.
module tb_fifo_read_streamer;
    localparam int DW = 8;
    localparam int CW = 4;

    logic          clk = 1'b0, rst_n = 1'b0, fifo_empty = 1'b1, out_ready = 1'b0;
    logic [DW-1:0] read_data = '0;
    logic          read_en, out_valid;
    logic [DW-1:0] out_data;
    logic [1:0]    out_level;
    logic [CW-1:0] out_count;

    always #5 clk = ~clk;

    fifo_read_streamer #(.data_size(DW), .cnt_size(CW)) dut (
        .read_clk(clk), .read_rst_n(rst_n), .fifo_empty(fifo_empty), .read_data(read_data),
        .read_en(read_en), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_level(out_level), .out_count(out_count)
    );

    int errors = 0, checks = 0;
    logic [DW-1:0] fq[$], sb[$];
    int exp_level = 0, ncount = 0, cyc = 0, re_pulses = 0, first_x = -1, last_x = -1;
    bit inflight_m = 1'b0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push(input logic [DW-1:0] w);
        fq.push_back(w);
        sb.push_back(w);
    endtask

    task automatic tick(input bit rst, input bit rdy);
        bit re_s, pop_s;
        int e, drop;
        rst_n = !rst;
        out_ready = rdy;
        fifo_empty = (fq.size() == 0);
        @(negedge clk);
        check("overread", int'(read_en && fifo_empty), 0);
        if (rst) begin
            check("rst_read_en", int'(read_en), 0);
            check("rst_data", int'(out_data), 0);
        end
        check("level", int'(out_level), exp_level);
        check("valid", int'(out_valid), int'(exp_level != 0));
        check("count", int'(out_count), ncount % (1 << CW));
        pop_s = (exp_level != 0) && rdy && !rst;
        if (pop_s) begin
            e = (sb.size() > 0) ? int'(sb[0]) : -1;
            check("data", int'(out_data), e);
            if (sb.size() > 0) void'(sb.pop_front());
            if (first_x < 0) first_x = cyc;
            last_x = cyc;
        end
        re_s = read_en;
        re_pulses += int'(re_s);
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            drop = exp_level + int'(inflight_m);
            repeat (drop) if (sb.size() > 0) void'(sb.pop_front());
            exp_level = 0;
            inflight_m = 1'b0;
            ncount = 0;
        end else begin
            if (pop_s) ncount++;
            exp_level = exp_level - int'(pop_s) + int'(inflight_m);
            inflight_m = re_s;
            if (re_s && fq.size() > 0) read_data = fq.pop_front();
        end
    endtask

    initial begin
        int base, p0, pushed, guard;
        logic [DW-1:0] w;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        // reset holds off reads even with data available
        push(8'hA1);
        push(8'hA2);
        tick(1, 0);
        tick(1, 0);
        repeat (6) tick(0, 1);
        // drain of 8 words at full rate
        tick(1, 0);
        for (int i = 1; i <= 8; i++) push(8'(i * 17));
        base = cyc;
        first_x = -1;
        repeat (12) tick(0, 1);
        check("t2_first", first_x - base, 2);
        check("t2_last", last_x - base, 9);
        check("t2_count", int'(out_count), 8);
        check("t2_idle_re", int'(read_en), 0);
        // backpressure
        tick(1, 0);
        for (int i = 0; i < 4; i++) push(8'(8'h30 + i));
        p0 = re_pulses;
        repeat (6) tick(0, 0);
        check("t3_pulses", re_pulses - p0, 2);
        check("t3_level", int'(out_level), 2);
        check("t3_head", int'(out_data), 8'h30);
        repeat (8) tick(0, 1);
        check("t3_count", int'(out_count), 4);
        // reset with a full buffer, then while streaming
        tick(1, 0);
        for (int i = 0; i < 6; i++) push(8'(8'h50 + i));
        repeat (5) tick(0, 0);
        tick(1, 0);
        repeat (8) tick(0, 1);
        check("t5_count", int'(out_count), 4);
        for (int i = 0; i < 6; i++) push(8'(8'h60 + i));
        repeat (3) tick(0, 1);
        tick(1, 1);
        repeat (10) tick(0, 1);
        check("t5_empty_sb", sb.size(), 0);
        // counter wrap
        tick(1, 0);
        for (int i = 0; i < 17; i++) push(8'(8'h80 + i));
        repeat (22) tick(0, 1);
        check("t6_count", int'(out_count), 1);
        // random traffic
        tick(1, 0);
        pushed = 0;
        guard = 0;
        while ((pushed < 1000 || ncount < 1000) && guard < 20000) begin
            if (pushed < 1000 && $urandom_range(0, 9) < 5) begin
                w = 8'($urandom);
                push(w);
                pushed++;
            end
            tick(0, 1'($urandom_range(0, 1)));
            guard++;
        end
        check("t4_delivered", ncount, 1000);
        check("t4_count", int'(out_count), 1000 % (1 << CW));
        check("t4_empty_sb", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
